// File: rtl/ddr3_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ddr3_cmd_ctrl: DDR3 power-up sequencer, closed-page command issue, refresh |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ddr3_cmd_ctrl #(
  parameter int BA_W   = 3,
  parameter int ROW_W  = 14,
  parameter int COL_W  = 10,
  parameter int T_RST  = 200,
  parameter int T_CKE  = 500,
  parameter int T_MRD  = 4,
  parameter int T_ZQ   = 512,
  parameter int T_RCD  = 6,
  parameter int T_RTP  = 4,
  parameter int T_WR   = 12,
  parameter int T_RP   = 6,
  parameter int T_RFC  = 64,
  parameter int T_REFI = 3120,
  parameter logic [ROW_W-1:0] MR0 = '0,
  parameter logic [ROW_W-1:0] MR1 = '0,
  parameter logic [ROW_W-1:0] MR2 = '0,
  parameter logic [ROW_W-1:0] MR3 = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [BA_W-1:0]  req_bank,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  output logic             ddr_rst_n,
  output logic             cke,
  output logic             cs_n,
  output logic             ras_n,
  output logic             cas_n,
  output logic             we_n,
  output logic             odt,
  output logic [BA_W-1:0]  ba,
  output logic [ROW_W-1:0] addr,
  output logic             init_done,
  output logic             rd_issue,
  output logic             wr_issue,
  output logic             ref_miss
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX  = max2(max2(max2(T_RST, T_CKE), max2(T_ZQ, T_RFC)),
                               max2(max2(T_MRD, T_RCD), max2(max2(T_RTP, T_WR), T_RP)));
  localparam int CNT_W  = $clog2(T_MAX + 1);
  localparam int REFI_W = $clog2(T_REFI + 1);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_DES  = 4'b1111;
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ZQCL = 4'b0110;
  localparam logic [ROW_W-1:0] ADDR_A10 = ROW_W'(11'h400);

  typedef enum logic [4:0] {
    RST_HOLD, CKE_HOLD, MRS2, MRS3, MRS1, MRS0, ZQCL, INIT_WAIT, IDLE,
    ACT, RCD_WAIT, RDWR, RTP_WAIT, PRE, RP_WAIT, REF, RFC_WAIT
  } state_t;

  // Gap counter load: the next command lands exactly t cycles after this one.
  function automatic logic [CNT_W-1:0] ld(input int t);
    return CNT_W'(t - 1);
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REFI_W-1:0] refi_q, refi_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [BA_W-1:0]   ba_q, ba_d, lat_bank_q, lat_bank_d;
  logic [ROW_W-1:0]  addr_q, addr_d;
  logic [COL_W-1:0]  lat_col_q, lat_col_d;
  logic              lat_write_q, lat_write_d;
  logic              rst_n_q, rst_n_d, cke_q, cke_d, odt_q, odt_d;
  logic              init_done_q, init_done_d, pend_q, pend_d;
  logic              rd_issue_q, rd_issue_d, wr_issue_q, wr_issue_d;
  logic              ref_miss_q, ref_miss_d;
  logic              cnt_zero, refi_wrap, ref_issue;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cke_q ? CMD_NOP : CMD_DES;
    ba_d        = ba_q;
    addr_d      = addr_q;
    lat_bank_d  = lat_bank_q;
    lat_col_d   = lat_col_q;
    lat_write_d = lat_write_q;
    rst_n_d     = rst_n_q;
    cke_d       = cke_q;
    odt_d       = odt_q;
    init_done_d = init_done_q;
    rd_issue_d  = 1'b0;
    wr_issue_d  = 1'b0;
    cnt_zero    = (cnt_q == '0);
    if (!cnt_zero) cnt_d = cnt_q - CNT_W'(1);

    case (state_q)
      RST_HOLD: if (cnt_zero) begin
        state_d = CKE_HOLD; rst_n_d = 1'b1; cnt_d = ld(T_CKE);
      end
      CKE_HOLD: if (cnt_zero) begin
        state_d = MRS2; cke_d = 1'b1; cmd_d = CMD_MRS;
        ba_d = BA_W'(2); addr_d = MR2; cnt_d = ld(T_MRD);
      end
      MRS2: if (cnt_zero) begin
        state_d = MRS3; cmd_d = CMD_MRS; ba_d = BA_W'(3); addr_d = MR3; cnt_d = ld(T_MRD);
      end
      MRS3: if (cnt_zero) begin
        state_d = MRS1; cmd_d = CMD_MRS; ba_d = BA_W'(1); addr_d = MR1; cnt_d = ld(T_MRD);
      end
      MRS1: if (cnt_zero) begin
        state_d = MRS0; cmd_d = CMD_MRS; ba_d = BA_W'(0); addr_d = MR0; cnt_d = ld(T_MRD);
      end
      MRS0: if (cnt_zero) begin
        state_d = ZQCL; cmd_d = CMD_ZQCL; addr_d = ADDR_A10; cnt_d = ld(T_ZQ);
      end
      ZQCL, INIT_WAIT: begin
        state_d = INIT_WAIT;
        if (cnt_zero) begin
          state_d = IDLE; init_done_d = 1'b1;
        end
      end
      IDLE: if (pend_q) begin
        state_d = REF; cmd_d = CMD_REF; cnt_d = ld(T_RFC);
      end else if (req_valid) begin
        state_d = ACT; cmd_d = CMD_ACT; ba_d = req_bank; addr_d = req_row;
        lat_bank_d = req_bank; lat_col_d = req_col; lat_write_d = req_write;
        cnt_d = ld(T_RCD);
      end
      ACT, RCD_WAIT: begin
        state_d = RCD_WAIT;
        if (cnt_zero) begin
          state_d = RDWR;
          cmd_d = lat_write_q ? CMD_WR : CMD_RD;
          addr_d = '0;
          addr_d[COL_W-1:0] = lat_col_q;
          rd_issue_d = !lat_write_q;
          wr_issue_d = lat_write_q;
          odt_d = lat_write_q;
          cnt_d = lat_write_q ? ld(T_WR) : ld(T_RTP);
        end
      end
      RDWR, RTP_WAIT: begin
        state_d = RTP_WAIT;
        if (cnt_zero) begin
          state_d = PRE; cmd_d = CMD_PRE; ba_d = lat_bank_q; addr_d = '0;
          odt_d = 1'b0; cnt_d = ld(T_RP);
        end
      end
      PRE, RP_WAIT: begin
        state_d = cnt_zero ? IDLE : RP_WAIT;
      end
      REF, RFC_WAIT: begin
        state_d = cnt_zero ? IDLE : RFC_WAIT;
      end
      default: state_d = RST_HOLD;
    endcase
  end

  // A wrap while a refresh is still owed is reported, never queued twice.
  always_comb begin
    ref_issue  = (state_q == IDLE) && pend_q;
    refi_wrap  = init_done_q && (refi_q == REFI_W'(T_REFI - 1));
    refi_d     = (!init_done_q || refi_wrap) ? '0 : refi_q + REFI_W'(1);
    pend_d     = refi_wrap ? 1'b1 : (ref_issue ? 1'b0 : pend_q);
    ref_miss_d = refi_wrap && pend_q && !ref_issue;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RST_HOLD;
      cnt_q       <= CNT_W'(T_RST);
      refi_q      <= '0;
      cmd_q       <= CMD_DES;
      ba_q        <= '0;
      addr_q      <= '0;
      lat_bank_q  <= '0;
      lat_col_q   <= '0;
      lat_write_q <= 1'b0;
      rst_n_q     <= 1'b0;
      cke_q       <= 1'b0;
      odt_q       <= 1'b0;
      init_done_q <= 1'b0;
      pend_q      <= 1'b0;
      rd_issue_q  <= 1'b0;
      wr_issue_q  <= 1'b0;
      ref_miss_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      refi_q      <= refi_d;
      cmd_q       <= cmd_d;
      ba_q        <= ba_d;
      addr_q      <= addr_d;
      lat_bank_q  <= lat_bank_d;
      lat_col_q   <= lat_col_d;
      lat_write_q <= lat_write_d;
      rst_n_q     <= rst_n_d;
      cke_q       <= cke_d;
      odt_q       <= odt_d;
      init_done_q <= init_done_d;
      pend_q      <= pend_d;
      rd_issue_q  <= rd_issue_d;
      wr_issue_q  <= wr_issue_d;
      ref_miss_q  <= ref_miss_d;
    end
  end

  assign req_ready = (state_q == IDLE) && !pend_q;
  assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
  assign ddr_rst_n = rst_n_q;
  assign cke       = cke_q;
  assign odt       = odt_q;
  assign ba        = ba_q;
  assign addr      = addr_q;
  assign init_done = init_done_q;
  assign rd_issue  = rd_issue_q;
  assign wr_issue  = wr_issue_q;
  assign ref_miss  = ref_miss_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ddr3_cmd_ctrl: directed bench for ddr3_cmd_ctrl                         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ddr3_cmd_ctrl;

  localparam logic [3:0] C_DES = 4'b1111, C_NOP = 4'b0111, C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101, C_WR  = 4'b0100, C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001, C_MRS = 4'b0000, C_ZQ  = 4'b0110;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]  req_bank = '0;
  logic [13:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        req_ready, ddr_rst_n, cke, cs_n, ras_n, cas_n, we_n, odt;
  logic [2:0]  ba;
  logic [13:0] addr;
  logic        init_done, rd_issue, wr_issue, ref_miss;
  logic [3:0]  cmd;

  logic        v2 = 1'b0;
  logic        ready2, rst_n2, cke2, cs2, ras2, cas2, we2, odt2;
  logic [2:0]  ba2;
  logic [13:0] addr2;
  logic        done2, rd2, wr2, miss2;
  logic [3:0]  cmd2;

  int n_cmp = 0;
  int n_mis = 0;

  assign cmd  = {cs_n, ras_n, cas_n, we_n};
  assign cmd2 = {cs2, ras2, cas2, we2};

  always #5 clk = ~clk;

  ddr3_cmd_ctrl #(
    .T_RST(4), .T_CKE(4), .T_MRD(4), .T_ZQ(8), .T_RCD(3), .T_RTP(2), .T_WR(5),
    .T_RP(3), .T_RFC(10), .T_REFI(50), .MR0(14'h0120)
  ) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .ddr_rst_n(ddr_rst_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .odt(odt), .ba(ba), .addr(addr), .init_done(init_done),
    .rd_issue(rd_issue), .wr_issue(wr_issue), .ref_miss(ref_miss)
  );

  // Short refresh interval so a single write transaction spans two wraps.
  ddr3_cmd_ctrl #(
    .T_RST(4), .T_CKE(4), .T_MRD(4), .T_ZQ(8), .T_RCD(3), .T_RTP(2), .T_WR(5),
    .T_RP(3), .T_RFC(1), .T_REFI(5), .MR0(14'h0120)
  ) u_dut2 (
    .clk(clk), .reset(reset), .req_valid(v2), .req_ready(ready2),
    .req_write(1'b1), .req_bank(3'd1), .req_row(14'h0010), .req_col(10'h008),
    .ddr_rst_n(rst_n2), .cke(cke2), .cs_n(cs2), .ras_n(ras2), .cas_n(cas2),
    .we_n(we2), .odt(odt2), .ba(ba2), .addr(addr2), .init_done(done2),
    .rd_issue(rd2), .wr_issue(wr2), .ref_miss(miss2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_rst_n"}, ddr_rst_n, 0);
    chk({p, "_cke"}, cke, 0);
    chk({p, "_cmd"}, cmd, C_DES);
    chk({p, "_ba"}, ba, 0);
    chk({p, "_addr"}, addr, 0);
    chk({p, "_odt"}, odt, 0);
    chk({p, "_init_done"}, init_done, 0);
    chk({p, "_ready"}, req_ready, 0);
    chk({p, "_pulses"}, {rd_issue, wr_issue, ref_miss}, 0);
  endtask

  // Releases reset and walks the init sequence; optionally runs the
  // refresh-starvation scenario on the second instance alongside it.
  task automatic init_seq(input bit starve);
    int nref2 = 0;
    int nmiss2 = 0;
    int last = starve ? 50 : 33;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= last; c++) begin
      step();
      case (c)
        4:  chk("rst_n_c4", ddr_rst_n, 0);
        5:  begin chk("rst_n_c5", ddr_rst_n, 1); chk("cke_c5", cke, 0); end
        8:  chk("cke_c8", cke, 0);
        9:  begin
              chk("cke_c9", cke, 1); chk("mrs2_cmd", cmd, C_MRS);
              chk("mrs2_ba", ba, 2); chk("mrs2_addr", addr, 0);
            end
        10: chk("nop_c10", cmd, C_NOP);
        12: chk("nop_c12", cmd, C_NOP);
        13: begin chk("mrs3_cmd", cmd, C_MRS); chk("mrs3_ba", ba, 3); end
        17: begin chk("mrs1_cmd", cmd, C_MRS); chk("mrs1_ba", ba, 1); end
        21: begin
              chk("mrs0_cmd", cmd, C_MRS); chk("mrs0_ba", ba, 0);
              chk("mrs0_addr", addr, 14'h0120);
            end
        25: begin chk("zqcl_cmd", cmd, C_ZQ); chk("zqcl_a10", addr[10], 1); end
        32: begin chk("init_done_c32", init_done, 0); chk("ready_c32", req_ready, 0); end
        33: begin chk("init_done_c33", init_done, 1); chk("ready_c33", req_ready, 1); end
        default: ;
      endcase
      if (starve) begin
        if (c >= 34 && c <= 47) begin
          if (cmd2 == C_REF) nref2++;
          if (miss2) nmiss2++;
        end
        if (c == 33) v2 = 1'b1;
        if (c == 34) begin chk("starve_act", cmd2, C_ACT); v2 = 1'b0; end
        if (c == 37) chk("starve_wr", cmd2, C_WR);
        if (c == 46) chk("starve_ref_c46", cmd2, C_REF);
      end
    end
    if (starve) begin
      chk("starve_miss_count", nmiss2, 1);
      chk("starve_ref_count", nref2, 1);
    end
  endtask

  initial begin
    bit found;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    init_seq(1'b0);

    // Read, H = 33
    req_valid = 1'b1; req_write = 1'b0;
    req_bank = 3'd5; req_row = 14'h1ABC; req_col = 10'h03F;
    step();
    chk("rd_act_cmd", cmd, C_ACT); chk("rd_act_ba", ba, 5);
    chk("rd_act_addr", addr, 14'h1ABC); chk("rd_ready_busy", req_ready, 0);
    req_valid = 1'b0;
    step(); step();
    chk("rd_gap_nop", cmd, C_NOP);
    step();
    chk("rd_cmd", cmd, C_RD); chk("rd_addr", addr, 14'h003F); chk("rd_ba", ba, 5);
    chk("rd_issue", rd_issue, 1); chk("rd_no_wr", wr_issue, 0); chk("rd_odt", odt, 0);
    step();
    chk("rd_issue_drop", rd_issue, 0);
    step();
    chk("rd_pre_cmd", cmd, C_PRE); chk("rd_pre_ba", ba, 5); chk("rd_pre_a10", addr[10], 0);
    step(); step();
    chk("rd_ready_h8", req_ready, 0);
    step();
    chk("rd_ready_h9", req_ready, 1);

    // Write, H = 42
    req_valid = 1'b1; req_write = 1'b1;
    step();
    chk("wr_act_cmd", cmd, C_ACT);
    req_valid = 1'b0;
    step(); step();
    chk("wr_odt_pre", odt, 0);
    step();
    chk("wr_cmd", cmd, C_WR); chk("wr_issue", wr_issue, 1);
    chk("wr_no_rd", rd_issue, 0); chk("wr_odt_h4", odt, 1);
    step(); step(); step(); step();
    chk("wr_odt_h8", odt, 1); chk("wr_nop_h8", cmd, C_NOP);
    step();
    chk("wr_pre_cmd", cmd, C_PRE); chk("wr_odt_pre_cycle", odt, 0);
    step(); step();
    chk("wr_ready_h11", req_ready, 0);
    step();
    chk("wr_ready_h12", req_ready, 1);

    // Refresh priority: wait for the pending refresh to drop req_ready in IDLE
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!req_ready) begin found = 1'b1; break; end
    end
    chk("refp_pending_seen", found, 1);
    chk("refp_idle_nop", cmd, C_NOP);
    req_valid = 1'b1; req_write = 1'b0;
    req_bank = 3'd2; req_row = 14'h0777; req_col = 10'h155;
    step();
    chk("refp_ref_cmd", cmd, C_REF); chk("refp_ready_ref", req_ready, 0);
    chk("refp_no_miss", ref_miss, 0);
    repeat (9) step();
    chk("refp_ready_ref9", req_ready, 0); chk("refp_no_act", cmd, C_NOP);
    step();
    chk("refp_ready_ref10", req_ready, 1);
    step();
    chk("refp_act_cmd", cmd, C_ACT); chk("refp_act_ba", ba, 2); chk("refp_act_addr", addr, 14'h0777);
    req_valid = 1'b0;
    step();

    // Mid-transaction reset in RCD_WAIT
    #2;
    reset = 1'b1;
    #1;
    chk_reset("midrst");
    init_seq(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/ddr3_cmd_ctrl.md
# ddr3_cmd_ctrl

Parametrised DDR3 command controller driving the DRAM command/address pins of `ddr3_interface` toward the `ddr3` device model. It runs the JEDEC power-up/initialisation sequence and then serves single-burst read/write requests over a valid/ready handshake under a closed-page policy. It inserts periodic auto-refresh with a configurable interval. All DRAM timing gaps are parameters counted in controller clock cycles.

## Interface
- `BA_W`, 3: bank address width.
- `ROW_W`, 14: row width; also the `addr` bus width.
- `COL_W`, 10: column width, ≤10.
- `T_RST`, 200: cycles `ddr_rst_n` is held low after reset.
- `T_CKE`, 500: cycles from `ddr_rst_n` rise to the first MRS, with `cke` low.
- `T_MRD`, 4; `T_ZQ`, 512; `T_RCD`, 6; `T_RTP`, 4; `T_WR`, 12; `T_RP`, 6; `T_RFC`, 64; `T_REFI`, 3120: command spacings, each ≥1.
- `MR0`..`MR3`, 0: `ROW_W`-bit mode-register values.
- `clk`  in  1  controller clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1; `req_ready`  out  1: request handshake.
- `req_write`  in  1: 1 = write, 0 = read.
- `req_bank` in `BA_W`; `req_row` in `ROW_W`; `req_col` in `COL_W`.
- `ddr_rst_n`, `cke`, `cs_n`, `ras_n`, `cas_n`, `we_n`, `odt`  out  1: DRAM pins.
- `ba`  out  `BA_W`; `addr`  out  `ROW_W`.
- `init_done`  out  1: initialisation is complete (sticky until reset).
- `rd_issue`, `wr_issue`  out  1: one-cycle pulse on the RD/WR command cycle.
- `ref_miss`  out  1: one-cycle pulse when a refresh interval expires while a refresh is still pending.

## Operation
- Command encoding is {cs_n,ras_n,cas_n,we_n}: NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, REF 0001, MRS 0000, ZQCL 0110.
- Every command lasts exactly one cycle. It is followed by NOPs so that the next command comes exactly T_x cycles later. A shared down-counter times all gaps.
- The FSM states are RST_HOLD, CKE_HOLD, MRS2, MRS3, MRS1, MRS0, ZQCL, INIT_WAIT, IDLE, ACT, RCD_WAIT, RDWR, RTP_WAIT, PRE, RP_WAIT, REF, RFC_WAIT.
- Initialisation sequence:
  - RST_HOLD drives `ddr_rst_n`=0 for T_RST cycles.
  - CKE_HOLD drives `ddr_rst_n`=1 and `cke`=0 for T_CKE cycles.
  - `cke` then goes to 1 and stays at 1.
  - Four MRS commands follow, spaced T_MRD apart, in order MR2, MR3, MR1, MR0.
  - For each MRS, `ba` = register number and `addr` = MRx.
  - ZQCL is issued with `addr[10]`=1, followed by a T_ZQ wait.
  - The FSM then enters IDLE and sets `init_done`.
- `req_ready` = (state==IDLE) && !ref_pending; it is combinational from registered state.
- Transaction (closed page): on accept, bank, row, col and write are latched.
  - ACT is issued with `ba`=bank and `addr`=row.
  - After T_RCD: RD or WR with `addr[COL_W-1:0]`=col, `addr[10]`=0 and other bits 0.
  - After T_RTP (read) or T_WR (write): PRE with `ba`=bank and `addr[10]`=0.
  - After T_RP the FSM returns to IDLE.
- `odt` is 1 from the WR cycle up to, but not including, the PRE cycle. It is 0 otherwise.
- Refresh:
  - A `T_REFI` counter runs free from `init_done`. It sets ref_pending when it wraps at T_REFI-1→0.
  - If ref_pending is already set at a wrap, `ref_miss` pulses and there is no stacking.
  - In IDLE with ref_pending, REF is issued next and ref_pending clears on the REF cycle. A T_RFC wait follows, then IDLE.
  - When a request and a pending refresh are both present in IDLE, REF wins and the request waits with `req_ready`=0.
  - A refresh that comes due mid-transaction waits until the FSM returns to IDLE.
- `ba`/`addr` hold their last value during NOPs. `rd_issue`/`wr_issue`/`ref_miss` are 0 except on their pulse cycle.

## Timing
- Reset values and async reset behaviour:
  - While `reset`=1, outputs are: `ddr_rst_n`=0, `cke`=0, `cs_n`/`ras_n`/`cas_n`/`we_n`=1, `ba`=0, `addr`=0, `odt`=0, `init_done`=0, `req_ready`=0, `rd_issue`/`wr_issue`/`ref_miss`=0.
  - Asserting `reset` mid-operation forces these values immediately, clears ref_pending and the REFI counter, and returns the FSM to RST_HOLD.
- Init cycle numbering: cycle 1 is the first rising edge after `reset` falls.
  - MRS2 is at cycle T_RST+T_CKE+1.
  - ZQCL is at cycle T_RST+T_CKE+4·T_MRD+1.
  - `init_done` rises at cycle T_RST+T_CKE+4·T_MRD+T_ZQ+1.
- Transaction latency: with the handshake edge at cycle H:
  - ACT at H+1.
  - RD/WR at H+1+T_RCD.
  - PRE at H+1+T_RCD+T_RTP (read) or H+1+T_RCD+T_WR (write).
  - `req_ready` is 1 again at PRE+T_RP.
- Refresh latency: REF comes 1 cycle after IDLE is entered with ref_pending set; IDLE is re-entered at REF+T_RFC.

## Test plan
Parameters for all scenarios: T_RST=4, T_CKE=4, T_MRD=4, T_ZQ=8, T_RCD=3, T_RTP=2, T_WR=5, T_RP=3, T_RFC=10, T_REFI=50, MR0=14'h0120.
- Init: release reset → `ddr_rst_n` rises at cycle 5; MRS at cycles 9/13/17/21 with `ba`=2/3/1/0 and `addr`=14'h0120 at cycle 21; ZQCL at 25; `init_done` at 33.
- Read: request bank 5, row 0x1ABC, col 0x3F accepted at H → ACT(`ba`=5, `addr`=0x1ABC) at H+1; RD (`addr`=0x3F) and `rd_issue` at H+4; PRE at H+6; `req_ready` at H+9.
- Write: same request with `req_write`=1 → WR at H+4, `odt`=1 for cycles H+4..H+8, PRE at H+9.
- Refresh priority: ref_pending set in IDLE together with `req_valid` → `req_ready`=0; REF next cycle; request accepted at REF+10.
- Refresh starvation: hold the bench in a state where REF cannot issue across two REFI wraps → `ref_miss` pulses exactly once, and only one REF is later issued.
- Mid-reset: assert `reset` at RCD_WAIT → all outputs take reset values in the same cycle; after release, the init sequence repeats with identical cycle numbers.
